mem_integrity_scoreboard: RTL and testbench

//  Synthesizable, parametrised read-after-write checker for a fixed-latency synchronous memory.
//  - Keeps a shadow copy of the memory plus one valid bit per address.
//  - Compares every returned read word against the shadow copy.
//  - Flags reads of never-written addresses.
//  - Keeps a saturating error count and captures the first failing transaction.
//  - Sits beside the memory port under test, in both RTL sims and emulation builds.

---
 rtl/mem_integrity_scoreboard_if.sv | 25 ++
 rtl/mem_integrity_scoreboard.sv | 170 +++++++++++++++++
 tb/tb_mem_integrity_scoreboard.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_integrity_scoreboard_if.sv
// Memory port bundle observed by the integrity scoreboard.
// master: whoever drives the memory port (requester plus memory read data).
// slave:  a passive observer such as the scoreboard.
interface mem_integrity_scoreboard_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]     rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be,
    output rd_en, rd_addr, rd_data
  );

  modport slave (
    input wr_en, wr_addr, wr_data, wr_be,
    input rd_en, rd_addr, rd_data
  );
endinterface

// File: rtl/mem_integrity_scoreboard.sv
// Read-after-write integrity checker for a fixed-latency synchronous memory.
// Keeps a byte-writable shadow copy plus a written flag per entry, carries the
// expected word of each read down an RD_LAT-deep pipe, and compares it against
// the returned read data. Errors pulse, count (saturating) and the first one
// is captured until cleared.
module mem_integrity_scoreboard #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int RAW_NEW    = 0,
  parameter int UNINIT_CHK = 1,
  parameter int CNT_W      = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  mem_integrity_scoreboard_if.slave   i_mem,
  input  logic                        i_clr_err,
  output logic                        o_err_mismatch,
  output logic                        o_err_uninit,
  output logic [CNT_W-1:0]            o_err_count,
  output logic                        o_first_vld,
  output logic [ADDR_W-1:0]           o_first_addr,
  output logic [DATA_W-1:0]           o_first_exp,
  output logic [DATA_W-1:0]           o_first_act
);

  localparam int DEPTH  = 2**ADDR_W;
  localparam int NBYTES = DATA_W/8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid;

  logic [RD_LAT-1:0] r_pipe_act;
  logic [RD_LAT-1:0] r_pipe_chk;
  logic [ADDR_W-1:0] r_pipe_addr [RD_LAT];
  logic [DATA_W-1:0] r_pipe_exp  [RD_LAT];

  logic              r_err_mismatch;
  logic              r_err_uninit;
  logic [CNT_W-1:0]  r_err_count;
  logic              r_first_vld;
  logic [ADDR_W-1:0] r_first_addr;
  logic [DATA_W-1:0] r_first_exp;
  logic [DATA_W-1:0] r_first_act;

  logic [DATA_W-1:0] w_rd_old;
  logic [DATA_W-1:0] w_rd_merged;
  logic              w_raw_hit;
  logic [DATA_W-1:0] w_rd_exp;
  logic              w_rd_vld;
  logic              w_exit_act;
  logic              w_exit_chk;
  logic [ADDR_W-1:0] w_exit_addr;
  logic [DATA_W-1:0] w_exit_exp;
  logic              w_mismatch;
  logic              w_uninit;
  logic              w_err;

  // Expected word and written flag for the read issued this cycle, including
  // the optional forwarding of a same-cycle write to the same address.
  always_comb begin
    w_rd_old    = r_mem[i_mem.rd_addr];
    w_rd_merged = w_rd_old;
    for (int b = 0; b < NBYTES; b++) begin
      if (i_mem.wr_be[b]) begin
        w_rd_merged[b*8 +: 8] = i_mem.wr_data[b*8 +: 8];
      end
    end
    w_raw_hit = (RAW_NEW != 0) && i_mem.wr_en && (i_mem.wr_addr == i_mem.rd_addr);
    if (w_raw_hit) begin
      w_rd_exp = w_rd_merged;
      w_rd_vld = r_valid[i_mem.rd_addr] | (|i_mem.wr_be);
    end else begin
      w_rd_exp = w_rd_old;
      w_rd_vld = r_valid[i_mem.rd_addr];
    end
  end

  // Shadow data: byte-masked update, never cleared so partial writes merge.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (i_mem.wr_en && i_mem.wr_be[b]) begin
        r_mem[i_mem.wr_addr][b*8 +: 8] <= i_mem.wr_data[b*8 +: 8];
      end
    end
  end

  // Written flags: cleared together on reset, set by any enabled byte.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_valid <= '0;
    end else if (i_mem.wr_en && (|i_mem.wr_be)) begin
      r_valid[i_mem.wr_addr] <= 1'b1;
    end
  end

  // Read tracking pipe; reset drops all in-flight compares.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_pipe_act <= '0;
      r_pipe_chk <= '0;
    end else begin
      r_pipe_act[0]  <= i_mem.rd_en;
      r_pipe_chk[0]  <= w_rd_vld;
      r_pipe_addr[0] <= i_mem.rd_addr;
      r_pipe_exp[0]  <= w_rd_exp;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_act[i]  <= r_pipe_act[i-1];
        r_pipe_chk[i]  <= r_pipe_chk[i-1];
        r_pipe_addr[i] <= r_pipe_addr[i-1];
        r_pipe_exp[i]  <= r_pipe_exp[i-1];
      end
    end
  end

  // Compare at pipe exit; unwritten entries skip the data compare entirely.
  always_comb begin
    w_exit_act  = r_pipe_act[RD_LAT-1];
    w_exit_chk  = r_pipe_chk[RD_LAT-1];
    w_exit_addr = r_pipe_addr[RD_LAT-1];
    w_exit_exp  = r_pipe_exp[RD_LAT-1];
    w_uninit    = w_exit_act && !w_exit_chk && (UNINIT_CHK != 0);
    w_mismatch  = w_exit_act && w_exit_chk && (i_mem.rd_data != w_exit_exp);
    w_err       = w_uninit || w_mismatch;
  end

  // Error pulses, saturating count and first-error capture; a new error
  // beats a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_err_mismatch <= 1'b0;
      r_err_uninit   <= 1'b0;
      r_err_count    <= '0;
      r_first_vld    <= 1'b0;
      r_first_addr   <= '0;
      r_first_exp    <= '0;
      r_first_act    <= '0;
    end else begin
      r_err_mismatch <= w_mismatch;
      r_err_uninit   <= w_uninit;
      if (i_clr_err) begin
        r_err_count <= w_err ? CNT_ONE : '0;
      end else if (w_err && (r_err_count != CNT_MAX)) begin
        r_err_count <= r_err_count + CNT_ONE;
      end
      if (w_err && (i_clr_err || !r_first_vld)) begin
        r_first_vld  <= 1'b1;
        r_first_addr <= w_exit_addr;
        r_first_exp  <= w_uninit ? '0 : w_exit_exp;
        r_first_act  <= i_mem.rd_data;
      end else if (i_clr_err) begin
        r_first_vld  <= 1'b0;
        r_first_addr <= '0;
        r_first_exp  <= '0;
        r_first_act  <= '0;
      end
    end
  end

  assign o_err_mismatch = r_err_mismatch;
  assign o_err_uninit   = r_err_uninit;
  assign o_err_count    = r_err_count;
  assign o_first_vld    = r_first_vld;
  assign o_first_addr   = r_first_addr;
  assign o_first_exp    = r_first_exp;
  assign o_first_act    = r_first_act;

endmodule

// File: tb/tb_mem_integrity_scoreboard.sv
// Directed bench: two scoreboards share one memory bus. u_a uses the default
// configuration (old-data RAW, 16-bit count); u_b forwards same-cycle writes
// and has a 2-bit count so saturation is reachable quickly.
module tb_mem_integrity_scoreboard;
  logic clk = 1'b0;
  logic reset_n;
  logic clr_err;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_integrity_scoreboard_if #(.ADDR_W(4), .DATA_W(32)) mem_bus ();

  logic        a_mism, a_uninit, a_fvld;
  logic [15:0] a_cnt;
  logic [3:0]  a_faddr;
  logic [31:0] a_fexp, a_fact;
  logic        b_mism, b_uninit, b_fvld;
  logic [1:0]  b_cnt;
  logic [3:0]  b_faddr;
  logic [31:0] b_fexp, b_fact;

  mem_integrity_scoreboard #(
    .ADDR_W(4), .DATA_W(32), .RD_LAT(1), .RAW_NEW(0), .UNINIT_CHK(1), .CNT_W(16)
  ) u_a (
    .i_clk(clk), .i_reset_n(reset_n), .i_mem(mem_bus.slave), .i_clr_err(clr_err),
    .o_err_mismatch(a_mism), .o_err_uninit(a_uninit), .o_err_count(a_cnt),
    .o_first_vld(a_fvld), .o_first_addr(a_faddr), .o_first_exp(a_fexp),
    .o_first_act(a_fact)
  );

  mem_integrity_scoreboard #(
    .ADDR_W(4), .DATA_W(32), .RD_LAT(1), .RAW_NEW(1), .UNINIT_CHK(1), .CNT_W(2)
  ) u_b (
    .i_clk(clk), .i_reset_n(reset_n), .i_mem(mem_bus.slave), .i_clr_err(clr_err),
    .o_err_mismatch(b_mism), .o_err_uninit(b_uninit), .o_err_count(b_cnt),
    .o_first_vld(b_fvld), .o_first_addr(b_faddr), .o_first_exp(b_fexp),
    .o_first_act(b_fact)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    mem_bus.wr_en   = 1'b1;
    mem_bus.wr_addr = addr;
    mem_bus.wr_data = data;
    mem_bus.wr_be   = be;
    tick();
    mem_bus.wr_en   = 1'b0;
  endtask

  // Issues one read and returns its data one cycle later; on return the
  // error pulses of that compare are visible.
  task automatic do_read(input logic [3:0] addr, input logic [31:0] data);
    mem_bus.rd_en   = 1'b1;
    mem_bus.rd_addr = addr;
    tick();
    mem_bus.rd_en   = 1'b0;
    mem_bus.rd_data = data;
    tick();
  endtask

  initial begin
    reset_n         = 1'b0;
    clr_err         = 1'b0;
    mem_bus.wr_en   = 1'b0;
    mem_bus.wr_addr = '0;
    mem_bus.wr_data = '0;
    mem_bus.wr_be   = '0;
    mem_bus.rd_en   = 1'b0;
    mem_bus.rd_addr = '0;
    mem_bus.rd_data = '0;
    tick();
    tick();
    chk("rst_cnt_a", a_cnt, 16'd0);
    chk("rst_fvld_a", a_fvld, 1'b0);
    chk("rst_pulses_a", {a_mism, a_uninit}, 2'b00);
    chk("rst_cnt_b", b_cnt, 2'd0);
    reset_n = 1'b1;

    // T1: full write then matching read
    do_write(4'd1, 32'h1234_5678, 4'hF);
    do_read(4'd1, 32'h1234_5678);
    chk("t1_pulses", {a_mism, a_uninit}, 2'b00);
    chk("t1_cnt", a_cnt, 16'd0);

    // T2: read of an unwritten address
    do_reset();
    do_read(4'd0, 32'h0000_DEAD);
    chk("t2_uninit", a_uninit, 1'b1);
    chk("t2_mism", a_mism, 1'b0);
    chk("t2_cnt", a_cnt, 16'd1);
    chk("t2_fvld", a_fvld, 1'b1);
    chk("t2_faddr", a_faddr, 4'd0);
    chk("t2_fexp", a_fexp, 32'h0);
    chk("t2_fact", a_fact, 32'h0000_DEAD);
    tick();
    chk("t2_one_pulse", a_uninit, 1'b0);
    chk("t2_cnt_hold", a_cnt, 16'd1);

    // T3: single-bit mismatch
    do_reset();
    do_write(4'd2, 32'hA5A5_A5A5, 4'hF);
    do_read(4'd2, 32'hA5A5_A5A4);
    chk("t3_mism", a_mism, 1'b1);
    chk("t3_uninit", a_uninit, 1'b0);
    chk("t3_faddr", a_faddr, 4'd2);
    chk("t3_fexp", a_fexp, 32'hA5A5_A5A5);
    chk("t3_fact", a_fact, 32'hA5A5_A5A4);
    chk("t3_cnt", a_cnt, 16'd1);

    // T4: byte-enabled partial write merges into the shadow word
    do_reset();
    do_write(4'd3, 32'h0, 4'hF);
    do_write(4'd3, 32'hFFFF_ABFF, 4'b0010);
    do_read(4'd3, 32'h0000_AB00);
    chk("t4_match", {a_mism, a_uninit}, 2'b00);
    chk("t4_cnt", a_cnt, 16'd0);
    do_read(4'd3, 32'h0000_AB01);
    chk("t4_mism", a_mism, 1'b1);
    chk("t4_fexp", a_fexp, 32'h0000_AB00);
    // a write with no byte enables leaves the entry unwritten
    do_write(4'd5, 32'h1111_1111, 4'h0);
    do_read(4'd5, 32'h1111_1111);
    chk("t4_be0_uninit", a_uninit, 1'b1);
    chk("t4_cnt2", a_cnt, 16'd2);

    // T5: same-cycle write and read to one address, prior value 7
    do_reset();
    do_write(4'd4, 32'd7, 4'hF);
    mem_bus.wr_en   = 1'b1;
    mem_bus.wr_addr = 4'd4;
    mem_bus.wr_data = 32'd1;
    mem_bus.wr_be   = 4'hF;
    mem_bus.rd_en   = 1'b1;
    mem_bus.rd_addr = 4'd4;
    tick();
    mem_bus.wr_en   = 1'b0;
    mem_bus.rd_en   = 1'b0;
    mem_bus.rd_data = 32'd7;
    tick();
    chk("t5_old_a", a_mism, 1'b0);
    chk("t5_new_b", b_mism, 1'b1);
    chk("t5_fexp_b", b_fexp, 32'd1);
    chk("t5_fact_b", b_fact, 32'd7);
    do_read(4'd4, 32'd1);
    chk("t5_after_a", a_mism, 1'b0);

    // T6: saturation of the 2-bit count and clear racing a new error
    do_reset();
    do_write(4'd6, 32'h10, 4'hF);
    for (int k = 1; k <= 5; k++) begin
      do_read(4'd6, 32'h10 + 32'(k));
    end
    chk("t6_sat_b", b_cnt, 2'd3);
    chk("t6_cnt_a", a_cnt, 16'd5);
    chk("t6_first_kept_b", b_fact, 32'h11);
    mem_bus.rd_en   = 1'b1;
    mem_bus.rd_addr = 4'd6;
    tick();
    mem_bus.rd_en   = 1'b0;
    mem_bus.rd_data = 32'h16;
    clr_err         = 1'b1;
    tick();
    clr_err         = 1'b0;
    chk("t6_clr_cnt_b", b_cnt, 2'd1);
    chk("t6_clr_cnt_a", a_cnt, 16'd1);
    chk("t6_clr_fvld_b", b_fvld, 1'b1);
    chk("t6_clr_fact_b", b_fact, 32'h16);
    chk("t6_clr_fexp_b", b_fexp, 32'h10);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t6_clr_only_cnt", b_cnt, 2'd0);
    chk("t6_clr_only_fvld", b_fvld, 1'b0);
    chk("t6_clr_only_fact", b_fact, 32'h0);

    // Reset while a read is in flight discards its compare
    mem_bus.rd_en   = 1'b1;
    mem_bus.rd_addr = 4'd9;
    tick();
    mem_bus.rd_en   = 1'b0;
    reset_n         = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_flight_uninit", a_uninit, 1'b0);
    chk("rst_flight_cnt", a_cnt, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
